// File: rtl/qspi_row_prefetch_if.sv
// rtl/qspi_row_prefetch_if.sv - request, row buffer and quad-SPI pad bundle for the row prefetcher
interface qspi_row_prefetch_if #(
    parameter int ROW_BYTES = 16,
    parameter int ADDR_W    = 24
);
    logic                   req_valid;
    logic                   req_ready;
    logic [ADDR_W-1:0]      req_addr;
    logic                   row_swap;
    logic [ROW_BYTES*8-1:0] row_data;
    logic                   row_valid;
    logic                   cache_full;
    logic                   busy;
    logic                   spi_sel_n;
    logic                   spi_clk_en;
    logic [3:0]             spi_io_out;
    logic [3:0]             spi_io_oe;
    logic [3:0]             spi_io_in;

    modport master (
        output req_valid, req_addr, row_swap, spi_io_in,
        input  req_ready, row_data, row_valid, cache_full, busy,
               spi_sel_n, spi_clk_en, spi_io_out, spi_io_oe
    );

    modport slave (
        input  req_valid, req_addr, row_swap, spi_io_in,
        output req_ready, row_data, row_valid, cache_full, busy,
               spi_sel_n, spi_clk_en, spi_io_out, spi_io_oe
    );
endinterface

// File: rtl/qspi_row_prefetch.sv
// rtl/qspi_row_prefetch.sv - quad-SPI row fetcher with cache/row double buffer; QSPI_SEQ_EN keeps CS low for sequential rows
module qspi_row_prefetch #(
    parameter int         ROW_BYTES = 16,
    parameter int         ADDR_W    = 24,
    parameter int         DUMMY_CYC = 8,
    parameter logic [7:0] READ_CMD  = 8'h6B
) (
    input  logic               px_clk,
    input  logic               reset,
    qspi_row_prefetch_if.slave bus
);
    localparam int ROW_W     = ROW_BYTES * 8;
    localparam int READ_LAST = 2 * ROW_BYTES;
    localparam int CNT_MAX_A = (ADDR_W - 1 > 7) ? ADDR_W - 1 : 7;
    localparam int CNT_MAX_B = (DUMMY_CYC - 1 > CNT_MAX_A) ? DUMMY_CYC - 1 : CNT_MAX_A;
    localparam int CNT_MAX   = (READ_LAST > CNT_MAX_B) ? READ_LAST : CNT_MAX_B;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);
    localparam int SH_W      = 8 + ADDR_W;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [3:0] {
        S_IDLE, S_SEL, S_CMD, S_ADDR, S_DUMMY, S_READ, S_DONE, S_HOLD, S_REL
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SH_W-1:0]  sh_q, sh_d;
    logic [ROW_W-1:0] cache_q, cache_d;
    logic [ROW_W-1:0] row_data_q, row_data_d;
    logic             cache_full_q, cache_full_d;
    logic             row_valid_q, row_valid_d;
    logic             sel_n_q, sel_n_d;
    logic             clk_en_q, clk_en_d;
    logic [3:0]       io_out_q, io_out_d;
    logic [3:0]       io_oe_q, io_oe_d;
    logic             req_ready;
    logic             accept;
    logic             swap_go;
`ifdef QSPI_SEQ_EN
    logic [ADDR_W-1:0] last_addr_q, last_addr_d;
    logic              seq_hit;

    assign req_ready = !reset && !cache_full_q && (state_q == S_IDLE || state_q == S_HOLD);
    assign seq_hit   = (bus.req_addr == last_addr_q + ADDR_W'(ROW_BYTES));
`else
    assign req_ready = !reset && !cache_full_q && (state_q == S_IDLE);
`endif

    assign accept  = bus.req_valid && req_ready;
    // Auto-prime: an empty row buffer takes the cache without waiting for the consumer.
    assign swap_go = cache_full_q && (bus.row_swap || !row_valid_q);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        sh_d         = sh_q;
        cache_d      = cache_q;
        cache_full_d = cache_full_q;
        row_data_d   = row_data_q;
        row_valid_d  = row_valid_q;
`ifdef QSPI_SEQ_EN
        last_addr_d  = last_addr_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_SEL;
                    cnt_d   = '0;
                end
            end
            S_SEL: begin
                state_d = S_CMD;
                cnt_d   = '0;
            end
            S_CMD: begin
                if (cnt_q == CNT_W'(7)) begin
                    state_d = S_ADDR;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_ADDR: begin
                if (cnt_q == CNT_W'(ADDR_W - 1)) begin
                    state_d = (DUMMY_CYC > 0) ? S_DUMMY : S_READ;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_DUMMY: begin
                if (cnt_q == CNT_W'(DUMMY_CYC - 1)) begin
                    state_d = S_READ;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_READ: begin
                // The pads add one cycle, so the first valid nibble arrives at n=1.
                if (cnt_q != '0) begin
                    cache_d = {cache_q[ROW_W-5:0], bus.spi_io_in};
                end
                if (cnt_q == CNT_W'(READ_LAST)) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_DONE: begin
                cache_full_d = 1'b1;
`ifdef QSPI_SEQ_EN
                state_d = S_HOLD;
`else
                state_d = S_IDLE;
`endif
            end
`ifdef QSPI_SEQ_EN
            S_HOLD: begin
                if (accept) begin
                    state_d = seq_hit ? S_READ : S_REL;
                    cnt_d   = '0;
                end
            end
            S_REL: begin
                state_d = S_SEL;
                cnt_d   = '0;
            end
`endif
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Command and address leave through one shift register, MSB first on IO0.
        if (accept) begin
            sh_d    = {READ_CMD, bus.req_addr};
            cache_d = '0;
`ifdef QSPI_SEQ_EN
            last_addr_d = bus.req_addr;
`endif
        end else if (state_d == S_CMD || state_d == S_ADDR) begin
            sh_d = {sh_q[SH_W-2:0], 1'b0};
        end

        if (swap_go) begin
            row_data_d   = cache_q;
            row_valid_d  = 1'b1;
            cache_full_d = 1'b0;
        end

`ifdef QSPI_SEQ_EN
        sel_n_d = (state_d == S_IDLE) || (state_d == S_REL);
`else
        sel_n_d = (state_d == S_IDLE) || (state_d == S_DONE);
`endif
        clk_en_d = (state_d == S_CMD) || (state_d == S_ADDR) ||
                   (state_d == S_DUMMY) || (state_d == S_READ);
        if (state_d == S_CMD || state_d == S_ADDR) begin
            io_oe_d  = 4'b0001;
            io_out_d = {3'b000, sh_q[SH_W-1]};
        end else begin
            io_oe_d  = 4'b0000;
            io_out_d = 4'b0000;
        end
    end

    always_ff @(posedge px_clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            sh_q         <= '0;
            cache_q      <= '0;
            cache_full_q <= 1'b0;
            row_data_q   <= '0;
            row_valid_q  <= 1'b0;
            sel_n_q      <= 1'b1;
            clk_en_q     <= 1'b0;
            io_out_q     <= 4'b0000;
            io_oe_q      <= 4'b0000;
`ifdef QSPI_SEQ_EN
            last_addr_q  <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sh_q         <= sh_d;
            cache_q      <= cache_d;
            cache_full_q <= cache_full_d;
            row_data_q   <= row_data_d;
            row_valid_q  <= row_valid_d;
            sel_n_q      <= sel_n_d;
            clk_en_q     <= clk_en_d;
            io_out_q     <= io_out_d;
            io_oe_q      <= io_oe_d;
`ifdef QSPI_SEQ_EN
            last_addr_q  <= last_addr_d;
`endif
        end
    end

    assign bus.req_ready  = req_ready;
    assign bus.row_data   = row_data_q;
    assign bus.row_valid  = row_valid_q;
    assign bus.cache_full = cache_full_q;
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.spi_sel_n  = sel_n_q;
    assign bus.spi_clk_en = clk_en_q;
    assign bus.spi_io_out = io_out_q;
    assign bus.spi_io_oe  = io_oe_q;
endmodule

// File: tb/tb_qspi_row_prefetch.sv
// tb/tb_qspi_row_prefetch.sv - directed bench for qspi_row_prefetch with a nibble-level flash model
module tb_qspi_row_prefetch;
    localparam logic [127:0] ROW0 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] ROW1 = 128'h101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] ROWF = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;

    logic px_clk = 1'b0;
    logic reset  = 1'b1;
    int   tests  = 0;
    int   fails  = 0;

    qspi_row_prefetch_if #(.ROW_BYTES(16), .ADDR_W(24)) bus ();

    qspi_row_prefetch #(
        .ROW_BYTES(16), .ADDR_W(24), .DUMMY_CYC(8), .READ_CMD(8'h6B)
    ) dut (
        .px_clk(px_clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 px_clk = ~px_clk;

    // Flash model: captures command/address from IO0 and returns byte (addr+i)-0x10.
    int          run = 0;
    logic        full_run = 1'b0;
    logic [23:0] f_addr = '0;

    always @(posedge px_clk) begin
        if (!bus.spi_clk_en || bus.spi_sel_n) begin
            run <= 0;
        end else begin
            run <= run + 1;
            if (run == 0) begin
                full_run <= (bus.spi_io_oe == 4'b0001);
                if (bus.spi_io_oe != 4'b0001) f_addr <= f_addr + 24'd16;
            end
            if (run >= 8 && run < 32 && bus.spi_io_oe == 4'b0001)
                f_addr <= {f_addr[22:0], bus.spi_io_out[0]};
        end
    end

    always @(negedge px_clk) begin
        int d;
        logic [7:0] b;
        d = run - (full_run ? 41 : 1);
        if (bus.spi_clk_en && !bus.spi_sel_n && run >= 1 && d >= 0) begin
            b = 8'(f_addr + 24'(d / 2)) - 8'h10;
            bus.spi_io_in = d[0] ? b[3:0] : b[7:4];
        end else begin
            bus.spi_io_in = 4'h0;
        end
    end

    task automatic step();
        @(posedge px_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic fetch(input logic [23:0] addr, input int exp_lat, input string tag);
        int k;
        check({tag, "_ready"}, bus.req_ready, 1);
        bus.req_addr  = addr;
        bus.req_valid = 1'b1;
        step();
        bus.req_valid = 1'b0;
        k = 0;
        while (bus.cache_full !== 1'b1 && k < 300) begin
            step();
            k++;
        end
        check({tag, "_lat"}, k, exp_lat);
    endtask

    initial begin
        logic [7:0]  cmd;
        logic [23:0] a;
        int          bad;
        int          n;

        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.row_swap  = 1'b0;
        reset = 1'b1;
        step();
        step();
        check("rst_ready", bus.req_ready, 0);
        check("rst_sel_n", bus.spi_sel_n, 1);
        check("rst_clk_en", bus.spi_clk_en, 0);
        check("rst_oe", bus.spi_io_oe, 0);
        check("rst_out", bus.spi_io_out, 0);
        check("rst_row", bus.row_data, 0);
        check("rst_valid", bus.row_valid, 0);
        check("rst_full", bus.cache_full, 0);
        check("rst_busy", bus.busy, 0);
        reset = 1'b0;
        step();

        // Test 1: full sequence timing and IO0 contents
        check("t1_ready", bus.req_ready, 1);
        bus.req_addr  = 24'h000410;
        bus.req_valid = 1'b1;
        step();
        bus.req_valid = 1'b0;
        check("t1_sel_n", bus.spi_sel_n, 0);
        check("t1_sel_clk_en", bus.spi_clk_en, 0);
        check("t1_busy", bus.busy, 1);
        cmd = '0;
        a   = '0;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            cmd = {cmd[6:0], bus.spi_io_out[0]};
            if (bus.spi_io_oe !== 4'b0001 || bus.spi_clk_en !== 1'b1 || bus.spi_io_out[3:1] !== 3'b000) bad++;
        end
        check("t1_cmd", cmd, 8'h6B);
        for (int i = 0; i < 24; i++) begin
            step();
            a = {a[22:0], bus.spi_io_out[0]};
            if (bus.spi_io_oe !== 4'b0001 || bus.spi_clk_en !== 1'b1 || bus.spi_io_out[3:1] !== 3'b000) bad++;
        end
        check("t1_addr", a, 24'h000410);
        check("t1_oe_cmd_addr", bad, 0);
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (bus.spi_io_oe !== 4'b0000 || bus.spi_clk_en !== 1'b1) bad++;
        end
        check("t1_dummy", bad, 0);
        bad = 0;
        for (int i = 0; i < 34; i++) begin
            step();
            if (bus.row_data !== '0 || bus.cache_full !== 1'b0) bad++;
        end
        check("t1_no_early_full", bad, 0);
        check("t1_done_sel_n", bus.spi_sel_n, 1);
        check("t1_done_clk_en", bus.spi_clk_en, 0);
        step();
        check("t1_full_at_75", bus.cache_full, 1);
        check("t1_ready_when_full", bus.req_ready, 0);

        // Test 2: auto-prime
        step();
        check("t2_valid", bus.row_valid, 1);
        check("t2_row", bus.row_data, ROW0);
        check("t2_full", bus.cache_full, 0);
        check("t2_busy", bus.busy, 0);

        // Test 3: second row stays in cache until swapped
        bus.req_addr  = 24'h000420;
        bus.req_valid = 1'b1;
        step();
        bus.req_valid = 1'b0;
        repeat (20) step();
        bus.row_swap = 1'b1;
        step();
        bus.row_swap = 1'b0;
        check("t3_early_swap_row", bus.row_data, ROW0);
        n = 21;
        while (bus.cache_full !== 1'b1 && n < 300) begin
            step();
            n++;
        end
        check("t3_lat", n, 75);
        step();
        check("t3_held_row", bus.row_data, ROW0);
        check("t3_held_full", bus.cache_full, 1);

        // Test 4: requests blocked while cache is full
        check("t4_ready", bus.req_ready, 0);
        bus.req_addr  = 24'h000430;
        bus.req_valid = 1'b1;
        step();
        check("t4_ignored_busy", bus.busy, 0);
        check("t4_ignored_sel", bus.spi_sel_n, 1);
        bus.req_valid = 1'b0;
        bus.row_swap  = 1'b1;
        step();
        bus.row_swap  = 1'b0;
        check("t4_swap_row", bus.row_data, ROW1);
        check("t4_swap_full", bus.cache_full, 0);
        check("t4_ready_after", bus.req_ready, 1);
        bus.row_swap = 1'b1;
        step();
        bus.row_swap = 1'b0;
        check("t4_empty_swap_row", bus.row_data, ROW1);
        check("t4_empty_swap_valid", bus.row_valid, 1);

        // Test 5: reset in READ n=10
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t5_pre_row", bus.row_data, 0);
        bus.req_addr  = 24'h000410;
        bus.req_valid = 1'b1;
        step();
        bus.req_valid = 1'b0;
        repeat (51) step();
        check("t5_in_read", bus.spi_clk_en, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t5_sel_n", bus.spi_sel_n, 1);
        check("t5_clk_en", bus.spi_clk_en, 0);
        check("t5_oe", bus.spi_io_oe, 0);
        check("t5_row", bus.row_data, 0);
        check("t5_full", bus.cache_full, 0);
        check("t5_busy", bus.busy, 0);
        step();
        fetch(24'h000410, 75, "t5_refetch");
        step();
        check("t5_refetch_row", bus.row_data, ROW0);

        // Test 6: sequential rows
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        fetch(24'h000000, 75, "t6a");
        step();
        check("t6a_row", bus.row_data, ROWF);
`ifdef QSPI_SEQ_EN
        check("t6a_hold_sel_n", bus.spi_sel_n, 0);
        fetch(24'h000010, 34, "t6b");
        bus.row_swap = 1'b1;
        step();
        bus.row_swap = 1'b0;
        check("t6b_row", bus.row_data, ROW0);
        bus.req_addr  = 24'h000100;
        bus.req_valid = 1'b1;
        step();
        bus.req_valid = 1'b0;
        check("t6c_release", bus.spi_sel_n, 1);
        step();
        check("t6c_reselect", bus.spi_sel_n, 0);
        n = 1;
        while (bus.cache_full !== 1'b1 && n < 300) begin
            step();
            n++;
        end
        check("t6c_lat", n, 76);
        bus.row_swap = 1'b1;
        step();
        bus.row_swap = 1'b0;
        check("t6c_row", bus.row_data, ROWF);
`else
        check("t6a_idle_sel_n", bus.spi_sel_n, 1);
        fetch(24'h000010, 75, "t6b");
        bus.row_swap = 1'b1;
        step();
        bus.row_swap = 1'b0;
        check("t6b_row", bus.row_data, ROW0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired tests=%0d", tests);
        $fatal(1, "timeout");
    end
endmodule
